rom_lut_pipe: RTL and testbench
===============================

// Module: rom_lut_pipe
// PURPOSE
//  Parametrised, pipelined successor of the 16x8 nibble-replicate lookup ROM.
//  Content is computed per address, with a selectable pattern MODE.
//  Read latency is LATENCY registered stages, with a valid/ready request and response handshake.
//  Sits between address generators and datapath consumers that may stall.
// PARAMETERS
//  ADDR_W   4   address width; depth = 2**ADDR_W
//  DATA_W   8   data width; must be >= ADDR_W
//  LATENCY  1   pipeline stages from request accept to out_valid; legal values 1..4
//  COUNT_W  16  width of the completed-read counter
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        synchronous, active-low reset
//  mode       in   2        pattern select, sampled with each accepted request
//  req_valid  in   1        request address valid
//  req_ready  out  1        block can accept a request this cycle
//  req_addr   in   ADDR_W   lookup address
//  out_valid  out  1        out_data valid
//  out_ready  in   1        consumer accepts out_data
//  out_data   out  DATA_W   lookup result
//  rd_count   out  COUNT_W  completed reads (out_valid & out_ready), saturating
// BEHAVIOUR
//  - Reset: rst_n low at a clk edge clears all stage valids, out_data and rd_count to 0.
//    req_ready is combinational and reads 1 from the first cycle after reset.
//    Reset mid-operation drops all in-flight reads; nothing is replayed.
//  - Pattern, with rep(a) defined as rep[i] = a[i % ADDR_W] for i in 0..DATA_W-1:
//    - MODE_REP  (2'd0): rep(addr); ADDR_W=4, DATA_W=8 gives 4'hA -> 8'hAA (legacy map).
//    - MODE_INV  (2'd1): ~rep(addr).
//    - MODE_ZEXT (2'd2): addr zero-extended to DATA_W.
//    - MODE_RSVD (2'd3): all zeros.
//  - Content is computed in stage 0 from the registered {addr, mode}. Later stages only carry it.
//  - Handshakes:
//    - Request is accepted on req_valid & req_ready.
//    - Response completes on out_valid & out_ready.
//    - Stage k advances when it is empty, or when stage k+1 advances (last stage: out_ready).
//    - req_ready = stage-0 advance condition. It is combinational from out_ready through the chain.
//    - With no stall, a request accepted at edge n gives out_valid high after edge n+LATENCY-1.
//      Back-to-back throughput is 1 per cycle.
//    - out_ready low freezes out_data/out_valid; all stages hold; no data is lost or duplicated.
//    - Accept and complete in the same cycle keeps full throughput.
//  - Address wrap: addr 2**ADDR_W-1 is valid; there is no out-of-range case.
//  - rd_count increments by 1 per completed read. It sticks at 2**COUNT_W-1 and never wraps.
//  - mode changes mid-stream affect only requests accepted after the change.
// STRUCTURE
//  - rom_lut_pkg holds:
//    - typedef enum logic [1:0] rom_mode_e {MODE_REP, MODE_INV, MODE_ZEXT, MODE_RSVD}
//    - function rom_pattern(addr, mode), parametrised via a DATA_W/ADDR_W-sized return.
//  - Sub-module rom_lut_stage: one valid/ready register slice (data, valid, advance logic).
//    Instantiated LATENCY times in a generate loop.
//  - Top level holds the pattern function call, the stage chain and rd_count.
// TESTING
//  1. Reset, default params, mode=0, sweep addr 0..F with out_ready=1
//     -> 16 outputs 8'h00,8'h11..8'hFF in order, 1/cycle, rd_count=16.
//  2. mode=1, addr 4'h3 -> 8'hCC; mode=2, addr 4'h3 -> 8'h03; mode=3 -> 8'h00.
//  3. LATENCY=3, stream addrs 1,2,3, hold out_ready=0 for 5 cycles, then release
//     -> out_data frozen at 8'h11, req_ready=0 once full, then 8'h11,8'h22,8'h33 with none lost.
//  4. ADDR_W=3, DATA_W=8, mode=0, addr 3'b101 -> 8'b01101101.
//  5. Assert rst_n=0 for 1 cycle with 2 reads in flight
//     -> out_valid=0 and rd_count=0 the next cycle; no stale data later.
//  6. COUNT_W=4, complete 20 reads -> rd_count saturates at 4'hF.

Source files
------------

// File: rtl/rom_lut_pkg.sv
// Shared types and the content generator for the pipelined lookup ROM.
package rom_lut_pkg;

    typedef enum logic [1:0] {
        MODE_REP  = 2'd0,
        MODE_INV  = 2'd1,
        MODE_ZEXT = 2'd2,
        MODE_RSVD = 2'd3
    } rom_mode_e;

    // Widest DATA_W the generator supports; callers size-cast the result down.
    localparam int ROM_MAX_W = 64;

    // Content for one address. addr must arrive zero-extended above addr_w.
    // rep(addr) tiles the address bits upward from bit 0 until data_w bits are
    // filled, which is the same as rep[i] = addr[i % addr_w].
    function automatic logic [ROM_MAX_W-1:0] rom_pattern(
        input logic [ROM_MAX_W-1:0] addr,
        input rom_mode_e            mode,
        input int                   addr_w,
        input int                   data_w
    );
        logic [ROM_MAX_W-1:0] rep;
        logic [ROM_MAX_W-1:0] mask;
        logic [ROM_MAX_W-1:0] result;
        rep = '0;
        for (int k = 0; k < ROM_MAX_W; k++) begin
            if (k * addr_w < data_w) begin
                rep = rep | (addr << (k * addr_w));
            end
        end
        if (data_w >= ROM_MAX_W) begin
            mask = '1;
        end else begin
            mask = (ROM_MAX_W'(1) << data_w) - ROM_MAX_W'(1);
        end
        rep = rep & mask;
        case (mode)
            MODE_REP:  result = rep;
            MODE_INV:  result = ~rep & mask;
            MODE_ZEXT: result = addr & mask;
            default:   result = '0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/rom_lut_stage.sv
// One valid/ready register slice of the lookup pipeline. The slice takes new
// contents whenever it is empty or its downstream neighbour is taking its
// current contents, so bubbles collapse and a full chain stalls as a unit.
module rom_lut_stage #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_down_adv,
    output logic              o_adv,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    assign o_adv   = ~r_valid | i_down_adv;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    // Slice register: load on advance; data only moves when a valid item arrives.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (o_adv) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/rom_lut_pipe.sv
// Pipelined pattern lookup ROM with request/response valid-ready handshakes.
// Content is generated from {addr, mode} as the request is accepted into the
// first slice; later slices only carry it. A saturating counter tracks reads.
module rom_lut_pipe #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 8,
    parameter int LATENCY = 1,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         mode,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [ADDR_W-1:0]  req_addr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [COUNT_W-1:0] rd_count
);

    import rom_lut_pkg::*;

    logic [DATA_W-1:0]  w_pattern;
    logic               w_complete;
    logic [COUNT_W-1:0] r_rd_count;

    assign w_pattern = DATA_W'(rom_pattern(ROM_MAX_W'(req_addr), rom_mode_e'(mode),
                                           ADDR_W, DATA_W));

    // Each slice reads its input from the slice before it and its advance
    // from the slice after it; the advance chain is purely combinational so
    // req_ready follows out_ready through a full pipe in the same cycle.
    for (genvar k = 0; k < LATENCY; k++) begin : g_stage
        logic              w_in_valid;
        logic [DATA_W-1:0] w_in_data;
        logic              w_down_adv;
        logic              w_adv;
        logic              w_valid;
        logic [DATA_W-1:0] w_data;

        if (k == 0) begin : g_head
            assign w_in_valid = req_valid;
            assign w_in_data  = w_pattern;
        end else begin : g_body
            assign w_in_valid = g_stage[k-1].w_valid;
            assign w_in_data  = g_stage[k-1].w_data;
        end

        if (k == LATENCY - 1) begin : g_tail
            assign w_down_adv = out_ready;
        end else begin : g_link
            assign w_down_adv = g_stage[k+1].w_adv;
        end

        rom_lut_stage #(
            .DATA_W (DATA_W)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_valid    (w_in_valid),
            .i_data     (w_in_data),
            .i_down_adv (w_down_adv),
            .o_adv      (w_adv),
            .o_valid    (w_valid),
            .o_data     (w_data)
        );
    end

    assign req_ready  = g_stage[0].w_adv;
    assign out_valid  = g_stage[LATENCY-1].w_valid;
    assign out_data   = g_stage[LATENCY-1].w_data;
    assign w_complete = out_valid & out_ready;
    assign rd_count   = r_rd_count;

    // Completed-read counter: sticks at all ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_count <= '0;
        end else if (w_complete && (r_rd_count != '1)) begin
            r_rd_count <= r_rd_count + COUNT_W'(1);
        end
    end

endmodule

// File: tb/tb_rom_lut_pipe.sv
// Bench for rom_lut_pipe: three parameterisations sharing one clock/reset.
//   A: defaults (4-bit addr, 8-bit data, latency 1, 16-bit count)
//   B: latency 3, 4-bit count
//   C: 3-bit addr, latency 2
module tb_rom_lut_pipe;

    logic clk;
    logic rst_n;

    logic [1:0]  a_mode, b_mode, c_mode;
    logic        a_req_valid, b_req_valid, c_req_valid;
    logic        a_req_ready, b_req_ready, c_req_ready;
    logic [3:0]  a_req_addr, b_req_addr;
    logic [2:0]  c_req_addr;
    logic        a_out_valid, b_out_valid, c_out_valid;
    logic        a_out_ready, b_out_ready, c_out_ready;
    logic [7:0]  a_out_data, b_out_data, c_out_data;
    logic [15:0] a_rd_count, c_rd_count;
    logic [3:0]  b_rd_count;

    int checks = 0;
    int errors = 0;

    rom_lut_pipe u_dut_a (
        .clk(clk), .rst_n(rst_n), .mode(a_mode), .req_valid(a_req_valid),
        .req_ready(a_req_ready), .req_addr(a_req_addr), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_data(a_out_data), .rd_count(a_rd_count)
    );

    rom_lut_pipe #(.ADDR_W(4), .DATA_W(8), .LATENCY(3), .COUNT_W(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .mode(b_mode), .req_valid(b_req_valid),
        .req_ready(b_req_ready), .req_addr(b_req_addr), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_data(b_out_data), .rd_count(b_rd_count)
    );

    rom_lut_pipe #(.ADDR_W(3), .DATA_W(8), .LATENCY(2), .COUNT_W(16)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .mode(c_mode), .req_valid(c_req_valid),
        .req_ready(c_req_ready), .req_addr(c_req_addr), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .out_data(c_out_data), .rd_count(c_rd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference content: bit i of the replicated word is address bit (i mod aw).
    function automatic logic [7:0] ref_pat(input int aw, input int addr, input int md);
        int r;
        r = 0;
        for (int i = 0; i < 8; i++) begin
            r = r + (((addr >> (i % aw)) & 1) << i);
        end
        case (md)
            0:       return 8'(r);
            1:       return 8'(255 - r);
            2:       return 8'(addr);
            default: return 8'h00;
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        a_req_valid = 0; b_req_valid = 0; c_req_valid = 0;
        a_out_ready = 1; b_out_ready = 1; c_out_ready = 1;
        a_mode = 0; b_mode = 0; c_mode = 0;
        a_req_addr = 0; b_req_addr = 0; c_req_addr = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_a_out_valid got=%b exp=0", a_out_valid); end
        checks++; if (a_out_data !== 8'h00) begin errors++; $display("FAIL reset_a_out_data got=%h exp=00", a_out_data); end
        checks++; if (a_rd_count !== 16'd0) begin errors++; $display("FAIL reset_a_rd_count got=%0d exp=0", a_rd_count); end
        checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL reset_a_req_ready got=%b exp=1", a_req_ready); end
        checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL reset_b_out_valid got=%b exp=0", b_out_valid); end
        checks++; if (b_req_ready !== 1'b1) begin errors++; $display("FAIL reset_b_req_ready got=%b exp=1", b_req_ready); end
        checks++; if (b_rd_count !== 4'd0) begin errors++; $display("FAIL reset_b_rd_count got=%0d exp=0", b_rd_count); end
        checks++; if (c_out_valid !== 1'b0) begin errors++; $display("FAIL reset_c_out_valid got=%b exp=0", c_out_valid); end
    endtask

    // Legacy map sweep on A: 16 results, one per cycle, one cycle after accept.
    task automatic test_sweep();
        logic [7:0] q[$];
        int idx = 0, n_cmp = 0, first_acc = -1, first_cmp = -1, last_cmp = -1;
        for (int cyc = 0; cyc < 60 && n_cmp < 16; cyc++) begin
            @(negedge clk);
            a_req_valid = (idx < 16);
            a_req_addr  = 4'(idx);
            a_mode      = 2'd0;
            a_out_ready = 1'b1;
            #1;
            if (a_out_valid && a_out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL sweep_data unexpected output got=%h", a_out_data);
                end else if (a_out_data !== q[0]) begin
                    errors++; $display("FAIL sweep_data got=%h exp=%h", a_out_data, q[0]);
                end
                if (q.size() != 0) void'(q.pop_front());
                if (first_cmp < 0) first_cmp = cyc;
                last_cmp = cyc;
                n_cmp++;
            end
            if (a_req_valid && a_req_ready) begin
                q.push_back(ref_pat(4, idx, 0));
                if (first_acc < 0) first_acc = cyc;
                idx++;
            end
        end
        @(negedge clk);
        a_req_valid = 1'b0;
        #1;
        checks++; if (n_cmp != 16) begin errors++; $display("FAIL sweep_count got=%0d exp=16", n_cmp); end
        checks++; if (first_cmp - first_acc != 1) begin errors++; $display("FAIL sweep_latency got=%0d exp=1", first_cmp - first_acc); end
        checks++; if (last_cmp - first_cmp != 15) begin errors++; $display("FAIL sweep_throughput span got=%0d exp=15", last_cmp - first_cmp); end
        checks++; if (a_rd_count !== 16'd16) begin errors++; $display("FAIL sweep_rd_count got=%0d exp=16", a_rd_count); end
    endtask

    // Directed mode checks then random modes/addresses with random stalls on A.
    task automatic test_modes();
        int mm[$], aa[$];
        logic [7:0] ee[$], q[$];
        int idx = 0, n_cmp = 0, n;
        mm.push_back(1); aa.push_back(3);  ee.push_back(8'hCC);
        mm.push_back(2); aa.push_back(3);  ee.push_back(8'h03);
        mm.push_back(3); aa.push_back(3);  ee.push_back(8'h00);
        mm.push_back(0); aa.push_back(10); ee.push_back(8'hAA);
        for (int i = 0; i < 40; i++) begin
            mm.push_back(int'($urandom_range(0, 3)));
            aa.push_back(int'($urandom_range(0, 15)));
            ee.push_back(ref_pat(4, aa[aa.size()-1], mm[mm.size()-1]));
        end
        n = mm.size();
        for (int cyc = 0; cyc < 600 && n_cmp < n; cyc++) begin
            @(negedge clk);
            if (idx < n && ($urandom % 4) != 0) begin
                a_req_valid = 1'b1; a_req_addr = 4'(aa[idx]); a_mode = 2'(mm[idx]);
            end else begin
                a_req_valid = 1'b0; a_req_addr = 4'($urandom); a_mode = 2'($urandom);
            end
            a_out_ready = (($urandom % 10) < 7);
            #1;
            if (a_out_valid && a_out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL modes_data unexpected output got=%h", a_out_data);
                end else if (a_out_data !== q[0]) begin
                    errors++; $display("FAIL modes_data item=%0d got=%h exp=%h", n_cmp, a_out_data, q[0]);
                end
                if (q.size() != 0) void'(q.pop_front());
                n_cmp++;
            end
            if (a_req_valid && a_req_ready) begin
                q.push_back(ee[idx]);
                idx++;
            end
        end
        @(negedge clk);
        a_req_valid = 1'b0;
        #1;
        checks++; if (n_cmp != n) begin errors++; $display("FAIL modes_count got=%0d exp=%0d", n_cmp, n); end
        checks++; if (a_rd_count !== 16'(16 + n)) begin errors++; $display("FAIL modes_rd_count got=%0d exp=%0d", a_rd_count, 16 + n); end
    endtask

    // 3-bit address on C: directed odd-width replication, then all addr x mode back-to-back.
    task automatic test_addr3();
        int mm[$], aa[$];
        logic [7:0] ee[$], q[$];
        int idx = 0, n_cmp = 0, n, first_acc = -1, first_cmp = -1, last_cmp = -1;
        mm.push_back(0); aa.push_back(5); ee.push_back(8'b0110_1101);
        mm.push_back(1); aa.push_back(5); ee.push_back(8'b1001_0010);
        for (int md = 0; md < 4; md++) begin
            for (int ad = 0; ad < 8; ad++) begin
                mm.push_back(md); aa.push_back(ad); ee.push_back(ref_pat(3, ad, md));
            end
        end
        n = mm.size();
        for (int cyc = 0; cyc < 200 && n_cmp < n; cyc++) begin
            @(negedge clk);
            c_req_valid = (idx < n);
            c_req_addr  = (idx < n) ? 3'(aa[idx]) : 3'd0;
            c_mode      = (idx < n) ? 2'(mm[idx]) : 2'd0;
            c_out_ready = 1'b1;
            #1;
            if (c_out_valid && c_out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL addr3_data unexpected output got=%h", c_out_data);
                end else if (c_out_data !== q[0]) begin
                    errors++; $display("FAIL addr3_data item=%0d got=%h exp=%h", n_cmp, c_out_data, q[0]);
                end
                if (q.size() != 0) void'(q.pop_front());
                if (first_cmp < 0) first_cmp = cyc;
                last_cmp = cyc;
                n_cmp++;
            end
            if (c_req_valid && c_req_ready) begin
                q.push_back(ee[idx]);
                if (first_acc < 0) first_acc = cyc;
                idx++;
            end
        end
        @(negedge clk);
        c_req_valid = 1'b0;
        #1;
        checks++; if (n_cmp != n) begin errors++; $display("FAIL addr3_count got=%0d exp=%0d", n_cmp, n); end
        checks++; if (first_cmp - first_acc != 2) begin errors++; $display("FAIL addr3_latency got=%0d exp=2", first_cmp - first_acc); end
        checks++; if (last_cmp - first_cmp != n - 1) begin errors++; $display("FAIL addr3_throughput span got=%0d exp=%0d", last_cmp - first_cmp, n - 1); end
    endtask

    // Latency-3 pipe on B: fill while consumer stalls 5 cycles, then drain.
    task automatic test_stall();
        logic [7:0] q[$];
        int idx = 0, n_cmp = 0;
        for (int cyc = 0; cyc < 40 && n_cmp < 4; cyc++) begin
            @(negedge clk);
            b_req_valid = (idx < 4);
            b_req_addr  = 4'(idx + 1);
            b_mode      = 2'd0;
            b_out_ready = (cyc >= 8);
            #1;
            if (cyc >= 3 && cyc < 8) begin
                checks++; if (b_out_valid !== 1'b1) begin errors++; $display("FAIL stall_out_valid cyc=%0d got=%b exp=1", cyc, b_out_valid); end
                checks++; if (b_out_data !== 8'h11) begin errors++; $display("FAIL stall_frozen_data cyc=%0d got=%h exp=11", cyc, b_out_data); end
                checks++; if (b_req_ready !== 1'b0) begin errors++; $display("FAIL stall_req_ready cyc=%0d got=%b exp=0", cyc, b_req_ready); end
            end
            if (b_out_valid && b_out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL stall_data unexpected output got=%h", b_out_data);
                end else if (b_out_data !== q[0]) begin
                    errors++; $display("FAIL stall_data got=%h exp=%h", b_out_data, q[0]);
                end
                if (q.size() != 0) void'(q.pop_front());
                n_cmp++;
            end
            if (b_req_valid && b_req_ready) begin
                q.push_back(ref_pat(4, idx + 1, 0));
                idx++;
            end
        end
        @(negedge clk);
        b_req_valid = 1'b0;
        #1;
        checks++; if (n_cmp != 4) begin errors++; $display("FAIL stall_count got=%0d exp=4", n_cmp); end
        checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL stall_drained got=%b exp=0", b_out_valid); end
        checks++; if (b_rd_count !== 4'd4) begin errors++; $display("FAIL stall_rd_count got=%0d exp=4", b_rd_count); end
    endtask

    // One-cycle reset with reads in flight on B: everything dropped, nothing replayed.
    task automatic test_reset_midflight();
        int seen = 0;
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge clk);
            b_req_valid = 1'b1; b_req_addr = 4'(cyc + 5); b_mode = 2'd0; b_out_ready = 1'b0;
        end
        @(negedge clk);
        b_req_valid = 1'b0;
        #1;
        checks++; if (b_out_valid !== 1'b1) begin errors++; $display("FAIL midreset_pre_valid got=%b exp=1", b_out_valid); end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        b_out_ready = 1'b1;
        #1;
        checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid got=%b exp=0", b_out_valid); end
        checks++; if (b_rd_count !== 4'd0) begin errors++; $display("FAIL midreset_rd_count got=%0d exp=0", b_rd_count); end
        checks++; if (b_req_ready !== 1'b1) begin errors++; $display("FAIL midreset_req_ready got=%b exp=1", b_req_ready); end
        checks++; if (a_rd_count !== 16'd0) begin errors++; $display("FAIL midreset_a_rd_count got=%0d exp=0", a_rd_count); end
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            #1;
            if (b_out_valid) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL midreset_stale got=%0d outputs exp=0", seen); end
    endtask

    // Random traffic on B past the 4-bit counter limit; count tracked every cycle.
    task automatic test_saturate();
        logic [7:0] q[$];
        int mm, aa, issued = 0, done = 0, exp_cnt;
        mm = 0; aa = 0;
        for (int cyc = 0; cyc < 500 && done < 30; cyc++) begin
            @(negedge clk);
            if (issued < 30 && ($urandom % 3) != 0) begin
                mm = int'($urandom_range(0, 3)); aa = int'($urandom_range(0, 15));
                b_req_valid = 1'b1; b_req_addr = 4'(aa); b_mode = 2'(mm);
            end else begin
                b_req_valid = 1'b0;
            end
            b_out_ready = (($urandom % 3) != 0);
            #1;
            exp_cnt = (done > 15) ? 15 : done;
            checks++; if (b_rd_count !== 4'(exp_cnt)) begin errors++; $display("FAIL sat_rd_count got=%0d exp=%0d", b_rd_count, exp_cnt); end
            if (b_out_valid && b_out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL sat_data unexpected output got=%h", b_out_data);
                end else if (b_out_data !== q[0]) begin
                    errors++; $display("FAIL sat_data item=%0d got=%h exp=%h", done, b_out_data, q[0]);
                end
                if (q.size() != 0) void'(q.pop_front());
                done++;
            end
            if (b_req_valid && b_req_ready) begin
                q.push_back(ref_pat(4, aa, mm));
                issued++;
            end
        end
        @(negedge clk);
        b_req_valid = 1'b0;
        #1;
        checks++; if (done != 30) begin errors++; $display("FAIL sat_count got=%0d exp=30", done); end
        checks++; if (b_rd_count !== 4'hF) begin errors++; $display("FAIL sat_final got=%h exp=f", b_rd_count); end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_modes();
        test_addr3();
        test_stall();
        test_reset_midflight();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
